// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: receives a framed, checksummed program image over a
// valid/ready byte stream and writes it little-endian into the byte-wide instruction RAM.
module inst_mem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;
    // Holds the remaining data-byte count; 2N never exceeds DEPTH once the length is accepted.
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    logic [2:0]        r_state;
    logic [7:0]        r_sum;
    logic [CNT_W-1:0]  r_left;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic [2:0]        w_nxt_state;
    logic [7:0]        w_nxt_sum;
    logic [CNT_W-1:0]  w_nxt_left;
    logic [ADDR_W-1:0] w_nxt_waddr;
    logic [1:0]        w_nxt_err_code;
    logic              w_nxt_we;
    logic [ADDR_W-1:0] w_nxt_mem_addr;
    logic [7:0]        w_nxt_mem_wdata;

    logic              w_accept;
    logic [31:0]       w_len_ext;
    logic              w_len_bad;
    logic [7:0]        w_csum_total;

    assign w_accept     = i_in_valid && r_in_ready;
    assign w_len_ext    = 32'(i_in_data);
    assign w_len_bad    = (w_len_ext == 32'd0) || (w_len_ext > MAX_WORDS) ||
                          ((BASE_ADDR + (32'd2 * w_len_ext)) > DEPTH);
    assign w_csum_total = r_sum + i_in_data;

    // Next-state, running checksum, write address and write-port update.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_sum       = r_sum;
        w_nxt_left      = r_left;
        w_nxt_waddr     = r_waddr;
        w_nxt_err_code  = r_err_code;
        w_nxt_we        = 1'b0;
        w_nxt_mem_addr  = r_mem_addr;
        w_nxt_mem_wdata = r_mem_wdata;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    w_nxt_state    = S_LEN;
                    w_nxt_err_code = ERR_NONE;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    w_nxt_sum   = i_in_data;
                    w_nxt_left  = CNT_W'({i_in_data, 1'b0});
                    w_nxt_waddr = ADDR_W'(BASE_ADDR);
                    if (w_len_bad) begin
                        w_nxt_state    = S_ERR;
                        w_nxt_err_code = ERR_LEN;
                    end else begin
                        w_nxt_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_nxt_sum       = w_csum_total;
                    w_nxt_left      = r_left - CNT_W'(1);
                    w_nxt_waddr     = r_waddr + ADDR_W'(1);
                    w_nxt_we        = 1'b1;
                    w_nxt_mem_addr  = r_waddr;
                    w_nxt_mem_wdata = i_in_data;
                    if (r_left == CNT_W'(1)) begin
                        w_nxt_state = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (w_csum_total == 8'd0) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_state    = S_ERR;
                        w_nxt_err_code = ERR_CSUM;
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State and output registers; status outputs are decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_sum       <= 8'd0;
            r_left      <= '0;
            r_waddr     <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_nxt_state;
            r_sum       <= w_nxt_sum;
            r_left      <= w_nxt_left;
            r_waddr     <= w_nxt_waddr;
            r_in_ready  <= (w_nxt_state == S_LEN) || (w_nxt_state == S_DATA) ||
                           (w_nxt_state == S_CSUM);
            r_mem_we    <= w_nxt_we;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
            r_cpu_hold  <= (w_nxt_state == S_LEN) || (w_nxt_state == S_DATA) ||
                           (w_nxt_state == S_CSUM) || (w_nxt_state == S_ERR);
            r_done      <= (w_nxt_state == S_DONE);
            r_err       <= (w_nxt_state == S_ERR);
            r_err_code  <= w_nxt_err_code;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;

endmodule
